layer_seq: RTL and testbench

//  Top-level sequencer for one conv/affine layer pass around batch_ctrl + out_ctrl.
//  On a start command it streams parameters (matw phase), then holds run high while n_batch

---
 rtl/layer_seq_pkg.sv | 15 +
 rtl/layer_seq_if.sv | 34 +++
 rtl/seq_cnt.sv | 42 ++++
 rtl/layer_seq.sv | 172 +++++++++++++++++
 tb/tb_layer_seq.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/layer_seq_pkg.sv
// Shared types and default sizing for the layer pass sequencer.
package layer_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3
    } seq_state_t;

    localparam int DEF_CNT_W   = 16;
    localparam int DEF_PRM_W   = 10;
    localparam int DEF_FLUSH_N = 2;

endpackage

// File: rtl/layer_seq_if.sv
// Command, stream-event and status bundle between the PS-side driver and layer_seq.
interface layer_seq_if #(
    parameter int CNT_W = 16,
    parameter int PRM_W = 10
);
    logic             start;
    logic             abort;
    logic [PRM_W-1:0] prm_words;
    logic [CNT_W-1:0] n_batch;
    logic             src_valid;
    logic             src_ready;
    logic             src_blk;
    logic             dst_hs_last;
    logic             irq_clr;
    logic             matw;
    logic             run;
    logic             last;
    logic             busy;
    logic             done;
    logic             irq;
    logic             aborted;

    modport master (
        output start, abort, prm_words, n_batch, src_valid, src_ready, src_blk,
               dst_hs_last, irq_clr,
        input  matw, run, last, busy, done, irq, aborted
    );

    modport slave (
        input  start, abort, prm_words, n_batch, src_valid, src_ready, src_blk,
               dst_hs_last, irq_clr,
        output matw, run, last, busy, done, irq, aborted
    );
endinterface

// File: rtl/seq_cnt.sv
// Up-counter with clear, load and enable; match_o flags the current value equal to term_i.
module seq_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         match_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear beats load beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_o = (cnt_q == term_i);

endmodule

// File: rtl/layer_seq.sv
// Sequencer for one conv/affine layer pass: parameter load, batch run, flush, status flags.
module layer_seq
    import layer_seq_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PRM_W   = DEF_PRM_W,
    parameter int FLUSH_N = DEF_FLUSH_N
) (
    input logic       clk,
    input logic       reset,
    layer_seq_if.slave bus
);
    localparam int FL_W = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;

    seq_state_t       state_q, state_d;
    logic [PRM_W-1:0] prm_sh_q;
    logic [CNT_W-1:0] nb_sh_q;
    logic             matw_q, run_q, last_q, busy_q, done_q, irq_q, aborted_q;

    logic start_acc_s, flush_entry_s, done_set_s, abort_act_s;
    logic prm_en_s, prm_hit_s, sblk_en_s, sblk_hit_s;
    logic dblk_en_s, dblk_hit_s, flush_en_s, flush_hit_s;

    assign abort_act_s = bus.abort && (state_q != S_IDLE);
    assign prm_en_s    = (state_q == S_LOAD) && bus.src_valid;
    // last_q doubles as the saturation flag so extra source blocks are not counted
    assign sblk_en_s   = (state_q == S_RUN) && bus.src_blk && !last_q;
    assign dblk_en_s   = (state_q == S_RUN) && bus.dst_hs_last;
    assign flush_en_s  = (state_q == S_FLUSH);

    // Next-state decode.
    always_comb begin
        state_d     = state_q;
        start_acc_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    start_acc_s = 1'b1;
                    if (bus.prm_words != {PRM_W{1'b0}}) begin
                        state_d = S_LOAD;
                    end else if (bus.n_batch != {CNT_W{1'b0}}) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    state_d = S_FLUSH;
                end else if (prm_en_s && prm_hit_s) begin
                    state_d = (nb_sh_q != {CNT_W{1'b0}}) ? S_RUN : S_FLUSH;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_FLUSH;
                end else if (dblk_en_s && dblk_hit_s) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (bus.abort) begin
                    state_d = S_FLUSH;
                end else if (flush_hit_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign flush_entry_s = (state_d == S_FLUSH) && ((state_q != S_FLUSH) || bus.abort);
    assign done_set_s    = (state_q == S_FLUSH) && (state_d == S_IDLE) && !aborted_q;

    // State, command shadows and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            prm_sh_q  <= {PRM_W{1'b0}};
            nb_sh_q   <= {CNT_W{1'b0}};
            matw_q    <= 1'b0;
            run_q     <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            irq_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc_s) begin
                prm_sh_q <= bus.prm_words;
                nb_sh_q  <= bus.n_batch;
            end
            matw_q <= (state_d == S_LOAD);
            // one dead cycle after matw drops before the datapath is released
            run_q  <= (state_d == S_RUN) && (state_q != S_LOAD);
            last_q <= (state_d == S_RUN) && (last_q || (sblk_en_s && sblk_hit_s));
            busy_q <= (state_d != S_IDLE);
            done_q <= done_set_s;
            irq_q  <= done_set_s || (irq_q && !bus.irq_clr);
            if (abort_act_s) begin
                aborted_q <= 1'b1;
            end else if (start_acc_s) begin
                aborted_q <= 1'b0;
            end
        end
    end

    seq_cnt #(.W(PRM_W)) u_prm_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (start_acc_s),
        .ld_i     (1'b0),
        .ld_val_i ({PRM_W{1'b0}}),
        .en_i     (prm_en_s),
        .term_i   (prm_sh_q - PRM_W'(1)),
        .match_o  (prm_hit_s)
    );

    seq_cnt #(.W(CNT_W)) u_sblk_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (start_acc_s),
        .ld_i     (1'b0),
        .ld_val_i ({CNT_W{1'b0}}),
        .en_i     (sblk_en_s),
        .term_i   (nb_sh_q - CNT_W'(1)),
        .match_o  (sblk_hit_s)
    );

    seq_cnt #(.W(CNT_W)) u_dblk_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (start_acc_s),
        .ld_i     (1'b0),
        .ld_val_i ({CNT_W{1'b0}}),
        .en_i     (dblk_en_s),
        .term_i   (nb_sh_q - CNT_W'(1)),
        .match_o  (dblk_hit_s)
    );

    seq_cnt #(.W(FL_W)) u_flush_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (flush_entry_s),
        .ld_i     (1'b0),
        .ld_val_i ({FL_W{1'b0}}),
        .en_i     (flush_en_s),
        .term_i   (FL_W'(FLUSH_N - 1)),
        .match_o  (flush_hit_s)
    );

    assign bus.matw    = matw_q;
    assign bus.run     = run_q;
    assign bus.last    = last_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.irq     = irq_q;
    assign bus.aborted = aborted_q;

endmodule

// File: tb/tb_layer_seq.sv
// Directed bench for layer_seq: per-cycle vector table plus hand-written corner sequences.
module tb_layer_seq;

    typedef struct {
        logic        st;
        logic        ab;
        logic [9:0]  pw;
        logic [15:0] nb;
        logic        sv;
        logic        sb;
        logic        dh;
        logic        cl;
        logic [6:0]  exp;  // {matw, run, last, busy, done, irq, aborted}
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl[25];

    layer_seq_if #(.CNT_W(16), .PRM_W(10)) bus ();

    layer_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {bus.matw, bus.run, bus.last, bus.busy, bus.done, bus.irq, bus.aborted};
    endfunction

    function automatic vec_t mk(input logic st, input logic ab, input logic [9:0] pw,
                                input logic [15:0] nb, input logic sv, input logic sb,
                                input logic dh, input logic cl, input logic [6:0] exp);
        vec_t v;
        v.st = st; v.ab = ab; v.pw = pw; v.nb = nb;
        v.sv = sv; v.sb = sb; v.dh = dh; v.cl = cl; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [6:0] want);
        logic [6:0] got;
        got = outs();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got={matw,run,last,busy,done,irq,aborted}=%b want=%b", nm, got, want);
        end
    endtask

    // Drive one cycle of inputs, clock it, then compare the registered outputs.
    task automatic step(input string nm, input vec_t v);
        bus.start = v.st; bus.abort = v.ab; bus.prm_words = v.pw; bus.n_batch = v.nb;
        bus.src_valid = v.sv; bus.src_blk = v.sb; bus.dst_hs_last = v.dh; bus.irq_clr = v.cl;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.src_valid = 1'b0; bus.src_blk = 1'b0;
        bus.dst_hs_last = 1'b0; bus.irq_clr = 1'b0;
        chk(nm, v.exp);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.prm_words = 10'd0; bus.n_batch = 16'd0;
        bus.src_valid = 1'b0; bus.src_ready = 1'b1; bus.src_blk = 1'b0;
        bus.dst_hs_last = 1'b0; bus.irq_clr = 1'b0;

        // pass 1: prm=4, n=2; pass 2: prm=0, n=1; pass 3: prm=0, n=0; then abort+start in IDLE
        tbl[0]  = mk(1'b1, 1'b0, 10'd4, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1001000);
        tbl[1]  = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1001000);
        tbl[2]  = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1001000);
        tbl[3]  = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1001000);
        tbl[4]  = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0001000);
        tbl[5]  = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0101000);
        tbl[6]  = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0101000);
        tbl[7]  = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0111000);
        tbl[8]  = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0111000);
        tbl[9]  = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0001000);
        tbl[10] = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000);
        tbl[11] = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000110);
        tbl[12] = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000010);
        tbl[13] = mk(1'b0, 1'b0, 10'd4, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000);
        tbl[14] = mk(1'b1, 1'b0, 10'd0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0101000);
        tbl[15] = mk(1'b0, 1'b0, 10'd0, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0111000);
        tbl[16] = mk(1'b0, 1'b0, 10'd0, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0001000);
        tbl[17] = mk(1'b0, 1'b0, 10'd0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000);
        tbl[18] = mk(1'b0, 1'b0, 10'd0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000110);
        tbl[19] = mk(1'b0, 1'b0, 10'd0, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000);
        tbl[20] = mk(1'b1, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000);
        tbl[21] = mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000);
        tbl[22] = mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000110);
        tbl[23] = mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000);
        tbl[24] = mk(1'b1, 1'b1, 10'd4, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold", 7'b0000000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_release", 7'b0000000);

        for (int i = 0; i < 25; i++) begin
            step($sformatf("tbl%0d", i), tbl[i]);
        end

        // abort in RUN after 1 of 3 batches, then abort restarting FLUSH
        step("ab_start",   mk(1'b1, 1'b0, 10'd0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0101000));
        step("ab_sblk",    mk(1'b0, 1'b0, 10'd0, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0101000));
        step("ab_dblk",    mk(1'b0, 1'b0, 10'd0, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0101000));
        step("ab_abort",   mk(1'b0, 1'b1, 10'd0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001001));
        step("ab_flush",   mk(1'b0, 1'b0, 10'd0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001001));
        step("ab_nodone",  mk(1'b0, 1'b0, 10'd0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001));
        step("ab_sticky",  mk(1'b0, 1'b0, 10'd0, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001));
        step("ab_clear",   mk(1'b1, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000));
        step("fab_flush",  mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000));
        step("fab_abort",  mk(1'b0, 1'b1, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001001));
        step("fab_restart",mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001001));
        step("fab_idle",   mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001));

        // start while busy, extra source blocks, coincident src_blk/dst_hs_last
        step("sat_start",  mk(1'b1, 1'b0, 10'd0, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0101000));
        step("sat_sb1",    mk(1'b0, 1'b0, 10'd0, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0101000));
        step("sat_sb2",    mk(1'b0, 1'b0, 10'd0, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0111000));
        step("sat_busyst", mk(1'b1, 1'b0, 10'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0111000));
        for (int i = 0; i < 3; i++) begin
            step($sformatf("sat_extra%0d", i),
                 mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0, 7'b0111000));
        end
        step("sat_both",   mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 7'b0111000));
        step("sat_dh2",    mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'b0001000));
        step("sat_flush",  mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000));
        step("sat_done",   mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000110));
        step("sat_clr",    mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000));

        // asynchronous reset in the middle of LOAD
        step("ar_start",   mk(1'b1, 1'b0, 10'd4, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1001000));
        step("ar_beat1",   mk(1'b0, 1'b0, 10'd4, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1001000));
        #2;
        reset = 1'b1;
        #1;
        chk("ar_async", 7'b0000000);
        #1;
        reset = 1'b0;

        // irq_clr coincident with the done that sets irq
        step("ic_start1",  mk(1'b1, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000));
        step("ic_flush1",  mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001000));
        step("ic_done1",   mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000110));
        step("ic_start2",  mk(1'b1, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001010));
        step("ic_flush2",  mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0001010));
        step("ic_setwins", mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000110));
        step("ic_clr",     mk(1'b0, 1'b0, 10'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
